// File: rtl/verif_cva6v_stream_fork_pkg.sv
// Shared types and helpers for the buffered stream fork and its per-output FIFOs.
package verif_cva6v_stream_fork_pkg;

    // Coarse FIFO fill state, used by assertions and coverage.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_status_e;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a read/write pointer covering 0..depth-1 (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/verif_cva6v_fork_fifo.sv
// Single-clock FIFO for one fork output. Registered head, no fall-through:
// a word pushed in cycle t is visible at the head from cycle t+1.
// Pointers wrap by explicit compare so DEPTH need not be a power of two.
module verif_cva6v_fork_fifo
    import verif_cva6v_stream_fork_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = cnt_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CNT_W-1:0]      usage,
    output logic                  full,
    output logic                  empty
);

    localparam int               PTR_W    = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr_q;
    logic [PTR_W-1:0]      rptr_q;
    logic [CNT_W-1:0]      usage_q;
    logic                  do_push;
    logic                  do_pop;
    fifo_status_e          status;

    assign full  = (usage_q == FULL_CNT);
    assign empty = (usage_q == '0);
    assign usage = usage_q;

    // Full blocks a push even if a pop happens in the same cycle; flush wins over both.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign data_out = mem[rptr_q];

    // Pointer and occupancy state; flush returns to the reset picture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            usage_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            usage_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                usage_q <= usage_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                usage_q <= usage_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: only entries between the pointers are ever observed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr_q] <= data_in;
        end
    end

    // Fill state decode for checkers.
    always_comb begin
        status = PARTIAL;
        if (empty) begin
            status = EMPTY;
        end else if (full) begin
            status = FULL;
        end
    end

`ifndef SYNTHESIS
    a_usage_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        usage_q <= FULL_CNT)
        else $error("fork fifo usage above DEPTH");

    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (status == FULL) |-> !do_push)
        else $error("fork fifo pushed while full");
`endif

endmodule

// File: rtl/verif_cva6v_stream_fork_buffered.sv
// Buffered stream fork: one valid/ready input is copied into a per-transaction
// subset (sel_i) of N_OUP outputs, each backed by its own DEPTH-entry FIFO.
//
// Handshake rule used on every port: a transfer happens in a cycle where
// valid and ready are both high at the rising clock edge; a producer that
// raised valid keeps valid and its payload stable until that transfer.
// ready_o is computed only from sel_i, flush_i and registered occupancy, so
// there is no combinational path from any ready_i to ready_o.
module verif_cva6v_stream_fork_buffered
    import verif_cva6v_stream_fork_pkg::*;
#(
    parameter int N_OUP      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = cnt_width(DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic [N_OUP-1:0]            sel_i,
    output logic [N_OUP-1:0]            valid_o,
    input  logic [N_OUP-1:0]            ready_i,
    output logic [N_OUP*DATA_WIDTH-1:0] data_o,
    output logic [N_OUP*CNT_W-1:0]      usage_o,
    output logic                        drop_o
);

    logic [N_OUP-1:0] fifo_full;
    logic [N_OUP-1:0] fifo_empty;
    logic [N_OUP-1:0] fifo_push;
    logic             in_hs;

    // Accept unless flushing or some selected FIFO is already full.
    always_comb begin
        ready_o = !flush_i;
        for (int i = 0; i < N_OUP; i++) begin
            if (sel_i[i] && fifo_full[i]) begin
                ready_o = 1'b0;
            end
        end
    end

    assign in_hs     = valid_i && ready_o;
    assign fifo_push = {N_OUP{in_hs}} & sel_i;
    // An accepted word with an empty mask goes nowhere; flag it.
    assign drop_o    = in_hs && (sel_i == '0);

    for (genvar g = 0; g < N_OUP; g++) begin : g_out
        verif_cva6v_fork_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .CNT_W      (CNT_W)
        ) u_fifo (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .flush    (flush_i),
            .push     (fifo_push[g]),
            .pop      (ready_i[g]),
            .data_in  (data_i),
            .data_out (data_o[g*DATA_WIDTH +: DATA_WIDTH]),
            .usage    (usage_o[g*CNT_W +: CNT_W]),
            .full     (fifo_full[g]),
            .empty    (fifo_empty[g])
        );

        assign valid_o[g] = !fifo_empty[g];

`ifndef SYNTHESIS
        a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (valid_o[g] && !ready_i[g] && !flush_i) |=>
            (valid_o[g] && $stable(data_o[g*DATA_WIDTH +: DATA_WIDTH])))
            else $error("output %0d changed while stalled", g);
`endif
    end

`ifndef SYNTHESIS
    a_params : assert property (@(posedge clk_i) (N_OUP >= 1) && (DEPTH >= 1))
        else $fatal(1, "N_OUP and DEPTH must both be >= 1");

    a_in_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_i && !ready_o) |=> (valid_i && $stable(data_i) && $stable(sel_i)))
        else $error("input changed while stalled");
`endif

endmodule

// File: tb/tb_verif_cva6v_stream_fork_buffered.sv
// Bench for the buffered stream fork. Two instances share clock, reset and
// flush: dut_a (DEPTH=2) and dut_b (DEPTH=3, non-power-of-two wrap), both
// with three outputs. A reference model of per-output queues predicts
// ready_o, drop_o, valid_o, usage_o and head data every cycle.
module tb_verif_cva6v_stream_fork_buffered;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk_i;
  logic          rst_ni;
  logic          flush_i;
  logic          valid_i [2];
  logic          ready_o [2];
  logic [DW-1:0] data_i  [2];
  logic [N-1:0]  sel_i   [2];
  logic [N-1:0]  valid_o [2];
  logic [N-1:0]  ready_i [2];
  logic [N*DW-1:0] data_o [2];
  logic [N*CW-1:0] usage_o [2];
  logic          drop_o  [2];

  logic [DW-1:0] exp_q [6][$];
  logic          hs [2];
  int            n_cmp;
  int            n_err;
  int            rand_busy;

  verif_cva6v_stream_fork_buffered #(
    .N_OUP(N), .DATA_WIDTH(DW), .DEPTH(2)
  ) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i[0]), .ready_o(ready_o[0]), .data_i(data_i[0]), .sel_i(sel_i[0]),
    .valid_o(valid_o[0]), .ready_i(ready_i[0]), .data_o(data_o[0]),
    .usage_o(usage_o[0]), .drop_o(drop_o[0])
  );

  verif_cva6v_stream_fork_buffered #(
    .N_OUP(N), .DATA_WIDTH(DW), .DEPTH(3)
  ) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i[1]), .ready_o(ready_o[1]), .data_i(data_i[1]), .sel_i(sel_i[1]),
    .valid_o(valid_o[1]), .ready_i(ready_i[1]), .data_o(data_o[1]),
    .usage_o(usage_o[1]), .drop_o(drop_o[1])
  );

  // clock / reset block
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // scoreboard: compare current outputs, then apply the cycle's pops/pushes
  task automatic monitor();
    forever begin
      @(negedge clk_i);
      for (int d = 0; d < 2; d++) begin
        logic exp_rdy;
        int   dep;
        dep = (d == 0) ? 2 : 3;
        if (!rst_ni) begin
          for (int i = 0; i < N; i++) exp_q[d*N+i].delete();
        end
        exp_rdy = !flush_i;
        for (int i = 0; i < N; i++) begin
          if (sel_i[d][i] && exp_q[d*N+i].size() == dep) exp_rdy = 1'b0;
        end
        check_eq($sformatf("ready_o[%0d]", d), 32'(ready_o[d]), 32'(exp_rdy));
        hs[d] = valid_i[d] && exp_rdy;
        check_eq($sformatf("drop_o[%0d]", d), 32'(drop_o[d]), 32'(hs[d] && sel_i[d] == '0));
        for (int i = 0; i < N; i++) begin
          int k;
          k = d*N + i;
          check_eq($sformatf("valid_o[%0d][%0d]", d, i), 32'(valid_o[d][i]),
                   32'(exp_q[k].size() != 0));
          check_eq($sformatf("usage_o[%0d][%0d]", d, i), 32'(usage_o[d][i*CW +: CW]),
                   32'(exp_q[k].size()));
          if (exp_q[k].size() != 0) begin
            check_eq($sformatf("data_o[%0d][%0d]", d, i), data_o[d][i*DW +: DW], exp_q[k][0]);
          end
        end
        if (rst_ni) begin
          if (flush_i) begin
            for (int i = 0; i < N; i++) exp_q[d*N+i].delete();
          end else begin
            for (int i = 0; i < N; i++) begin
              if (exp_q[d*N+i].size() != 0 && ready_i[d][i]) void'(exp_q[d*N+i].pop_front());
              if (hs[d] && sel_i[d][i]) exp_q[d*N+i].push_back(data_i[d]);
            end
          end
        end
      end
    end
  endtask

  // driver: hold a word until the model sees it accepted (bounded wait)
  task automatic send(input int d, input logic [DW-1:0] data, input logic [N-1:0] sel);
    valid_i[d] = 1'b1;
    data_i[d]  = data;
    sel_i[d]   = sel;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk_i);
      if (hs[d]) break;
    end
    check_eq($sformatf("accept[%0d]", d), 32'(hs[d]), 32'd1);
    #1;
    valid_i[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic rand_drive(input int d, input int words);
    for (int w = 0; w < words; w++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(d, $urandom, 3'($urandom_range(0, 7)));
    end
    rand_busy--;
  endtask

  task automatic rand_ready();
    while (rand_busy > 0) begin
      ready_i[0] = 3'($urandom_range(0, 7));
      ready_i[1] = 3'($urandom_range(0, 7));
      idle(1);
    end
    ready_i[0] = '1;
    ready_i[1] = '1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_ni = 1'b0;
    flush_i = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid_i[d] = 1'b0;
      data_i[d]  = '0;
      sel_i[d]   = '0;
      ready_i[d] = '0;
      hs[d]      = 1'b0;
    end
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    idle(1);

    // broadcast to all outputs, all ready
    ready_i[0] = 3'b111;
    send(0, 32'hA5, 3'b111);
    idle(3);

    // single output stalled: third word waits for the first pop
    ready_i[0] = 3'b000;
    send(0, 32'h1, 3'b010);
    send(0, 32'h2, 3'b010);
    fork
      send(0, 32'h3, 3'b010);
      begin idle(3); ready_i[0] = 3'b010; end
    join
    idle(4);

    // output 0 stalled and full: other outputs still served, mask to 0 blocks
    ready_i[0] = 3'b110;
    send(0, 32'h11, 3'b001);
    send(0, 32'h12, 3'b001);
    send(0, 32'h13, 3'b110);
    fork
      send(0, 32'h14, 3'b001);
      begin idle(3); ready_i[0] = 3'b111; end
    join
    idle(4);

    // empty mask: accepted and dropped
    send(0, 32'h55, 3'b000);
    idle(2);

    // full-rate streaming through output 2 of the DEPTH=3 instance
    ready_i[1] = 3'b100;
    for (int w = 0; w < 10; w++) send(1, 32'h200 + w, 3'b100);
    idle(4);

    // flush with occupancies 2,1,0 and pops requested during the flush
    ready_i[0] = 3'b000;
    send(0, 32'h21, 3'b011);
    send(0, 32'h22, 3'b001);
    flush_i = 1'b1;
    ready_i[0] = 3'b111;
    idle(1);
    flush_i = 1'b0;
    idle(3);

    // async reset in the middle of a stalled burst
    ready_i[0] = 3'b000;
    send(0, 32'h77, 3'b111);
    ready_i[1] = 3'b000;
    fork
      for (int w = 0; w < 5; w++) send(1, 32'h300 + w, 3'b111);
      begin
        repeat (6) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        check_eq("async_valid_a", 32'(valid_o[0]), 32'd0);
        check_eq("async_valid_b", 32'(valid_o[1]), 32'd0);
        check_eq("async_usage_b", 32'(usage_o[1]), 32'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
      end
    join
    ready_i[0] = 3'b111;
    ready_i[1] = 3'b111;
    idle(4);

    // random traffic with random back-pressure on both instances
    rand_busy = 2;
    fork
      rand_drive(0, 60);
      rand_drive(1, 60);
      rand_ready();
    join
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
